// File: rtl/n64_joybus_pkg.sv
// n64_joybus_pkg: shared constants for the N64 joybus device-side responder.
//   - command bytes accepted from the console
//   - identity / status bytes returned by the info and reset commands
//   - FSM state encoding
//   - timing multipliers, in microseconds of joybus time
package n64_joybus_pkg;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_STATE = 8'h01;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam logic [7:0] ID_HI = 8'h05;
  localparam logic [7:0] ID_LO = 8'h00;

  localparam logic [7:0] STATUS_PAK    = 8'h01;
  localparam logic [7:0] STATUS_NO_PAK = 8'h02;

  localparam int STOP_US   = 2;  // device stop bit low time
  localparam int BIT_US    = 4;  // one response bit cell
  localparam int ZERO_US   = 2;  // rx low time at or above this decodes as 0
  localparam int RX_ERR_US = 5;  // rx low time that marks a stuck line

  typedef enum logic [2:0] {
    IDLE,
    RX_LOW,
    RX_HIGH,
    RX_ERR,
    TURN,
    TX_BIT,
    TX_STOP,
    TX_GAP
  } state_t;

  function automatic logic is_known_cmd(input logic [7:0] c);
    return (c == CMD_INFO) || (c == CMD_STATE) || (c == CMD_RESET);
  endfunction

endpackage

// File: rtl/n64_joybus_sync.sv
// n64_joybus_sync: 2-FF synchroniser for the joy pad, optional 3-sample
// majority filter, and edge detection on the resulting level.
// Optional feature macro: JOYBUS_GLITCH_FILTER_EN (adds 2 cycles of latency
// and rejects 1-cycle pulses).
// Ports:
//   clk, reset_l  clock and async active-low reset
//   line_in       raw asynchronous line level
//   level         synchronised (and optionally filtered) level
//   fall, rise    single-cycle edge strobes on level
module n64_joybus_sync (
  input  logic clk,
  input  logic reset_l,
  input  logic line_in,
  output logic level,
  output logic fall,
  output logic rise
);

  // The joy line idles high, so every stage resets to 1 to avoid a
  // spurious falling edge when reset is released.
  logic [1:0] sync_q;
  logic       level_q;
  logic       joy_s;

  always_ff @(posedge clk or negedge reset_l) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_l) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], line_in};
  end

  assign joy_s = sync_q[1];

`ifdef JOYBUS_GLITCH_FILTER_EN
  logic [2:0] hist_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) hist_q <= 3'b111;
    else          hist_q <= {hist_q[1:0], joy_s};
  end

  // Two of three samples must agree, so a lone 1-cycle pulse never wins.
  assign level = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                 (hist_q[1] & hist_q[2]);
`else
  assign level = joy_s;
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) level_q <= 1'b1;
    else          level_q <= level;
  end

  assign fall = level_q & ~level;
  assign rise = ~level_q & level;

endmodule

// File: rtl/n64_joybus_device.sv
// n64_joybus_device: controller-side responder on one open-drain joy line.
// Decodes console command frames and answers 0x00/0xFF (info/reset) with
// 05 00 status and 0x01 (state) with the 32-bit buttons word.
// Optional feature macro: JOYBUS_GLITCH_FILTER_EN (rx majority filter).
// Ports:
//   clk, reset_l  clock and async active-low reset
//   joy_in        raw pad level of the joy line
//   joy_oe        1 = pull the line low, 0 = release
//   buttons       controller state, bits 31:24 sent first, MSB first
//   pak_present   reported in the status byte
//   busy          high whenever the FSM is not IDLE
//   cmd_valid     1-cycle pulse on an accepted command
//   cmd_byte      last accepted command
//   rx_error      1-cycle pulse on a malformed frame
module n64_joybus_device
  import n64_joybus_pkg::*;
#(
  parameter int US_CYCLES  = 50,
  parameter int TIMEOUT_US = 4,
  parameter int GAP_US     = 2
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        joy_in,
  output logic        joy_oe,
  input  logic [31:0] buttons,
  input  logic        pak_present,
  output logic        busy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        rx_error
);

  localparam int CNT_W = $clog2(RX_ERR_US * US_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX  = cnt_t'(RX_ERR_US * US_CYCLES);
  localparam cnt_t ZERO_TH  = cnt_t'(ZERO_US * US_CYCLES);
  localparam cnt_t RX_TO    = cnt_t'(TIMEOUT_US * US_CYCLES);
  localparam cnt_t TURN_END = cnt_t'(US_CYCLES - 1);
  localparam cnt_t BIT_END  = cnt_t'(BIT_US * US_CYCLES - 1);
  localparam cnt_t ONE_HI   = cnt_t'(US_CYCLES);
  localparam cnt_t ZERO_HI  = cnt_t'((BIT_US - 1) * US_CYCLES);
  localparam cnt_t STOP_END = cnt_t'(STOP_US * US_CYCLES - 1);
  localparam cnt_t GAP_END  = cnt_t'(GAP_US * US_CYCLES - 1);

  logic level, fall, rise;

  n64_joybus_sync u_sync (
    .clk     (clk),
    .reset_l (reset_l),
    .line_in (joy_in),
    .level   (level),
    .fall    (fall),
    .rise    (rise)
  );

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d, cnt_inc;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  rx_shift_q, rx_shift_d;   // 8 command bits plus the stop bit
  logic [31:0] tx_buf_q, tx_buf_d;
  logic [5:0]  tx_left_q, tx_left_d;
  logic [7:0]  cmd_byte_d, rx_byte;
  logic        cmd_valid_d, rx_error_d, joy_oe_d;

  assign rx_byte = rx_shift_q[8:1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);
  assign busy    = (state_q != IDLE);

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_inc;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_buf_d    = tx_buf_q;
    tx_left_d   = tx_left_q;
    cmd_byte_d  = cmd_byte;
    cmd_valid_d = 1'b0;
    rx_error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d   = RX_LOW;
          bit_cnt_d = '0;
        end
      end
      RX_LOW: begin
        if (rise) begin
          rx_shift_d = {rx_shift_q[7:0], (cnt_q < ZERO_TH)};
          bit_cnt_d  = (bit_cnt_q == 4'hF) ? bit_cnt_q : bit_cnt_q + 4'd1;
          state_d    = RX_HIGH;
          cnt_d      = '0;
        end else if (cnt_q == CNT_MAX) begin
          rx_error_d = 1'b1;
          state_d    = RX_ERR;
          cnt_d      = '0;
        end
      end
      RX_HIGH: begin
        // Timeout is checked first: a fall on the timeout cycle is dropped.
        if (cnt_q == RX_TO) begin
          cnt_d = '0;
          if (bit_cnt_q == 4'd9 && is_known_cmd(rx_byte)) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = rx_byte;
            state_d     = TURN;
            if (rx_byte == CMD_STATE) begin
              tx_buf_d  = buttons;
              tx_left_d = 6'd32;
            end else begin
              tx_buf_d  = {ID_HI, ID_LO,
                           pak_present ? STATUS_PAK : STATUS_NO_PAK, 8'h00};
              tx_left_d = 6'd24;
            end
          end else begin
            rx_error_d = 1'b1;
            state_d    = IDLE;
          end
        end else if (fall) begin
          state_d = RX_LOW;
          cnt_d   = '0;
        end
      end
      RX_ERR: begin
        // Only an unbroken high stretch counts toward recovery.
        if (!level) begin
          cnt_d = '0;
        end else if (cnt_q == RX_TO) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      TURN: begin
        if (cnt_q == TURN_END) begin
          state_d = TX_BIT;
          cnt_d   = '0;
        end
      end
      TX_BIT: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          tx_buf_d  = {tx_buf_q[30:0], 1'b0};
          tx_left_d = tx_left_q - 6'd1;
          if (tx_left_q == 6'd1) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (cnt_q == STOP_END) begin
          state_d = TX_GAP;
          cnt_d   = '0;
        end
      end
      TX_GAP: begin
        if (cnt_q == GAP_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Drive is decoded from next-state values so joy_oe is a clean flop.
    unique case (state_d)
      TX_BIT:  joy_oe_d = cnt_d < (tx_buf_d[31] ? ONE_HI : ZERO_HI);
      TX_STOP: joy_oe_d = 1'b1;
      default: joy_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_left_q  <= '0;
      cmd_byte   <= 8'h00;
      cmd_valid  <= 1'b0;
      rx_error   <= 1'b0;
      joy_oe     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_left_q  <= tx_left_d;
      cmd_byte   <= cmd_byte_d;
      cmd_valid  <= cmd_valid_d;
      rx_error   <= rx_error_d;
      joy_oe     <= joy_oe_d;
    end
  end

endmodule

// File: tb/tb_n64_joybus_device.sv
// tb_n64_joybus_device: console-side model driving command frames into the
// device over an open-drain loopback, with a response decoder feeding a
// byte scoreboard.
`timescale 1ns/1ps
module tb_n64_joybus_device;
  import n64_joybus_pkg::*;

  localparam int US = 4;
`ifdef JOYBUS_GLITCH_FILTER_EN
  localparam int FILT_LAT = 2;
`else
  localparam int FILT_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        console_low = 1'b0;
  logic        joy_in;
  logic        joy_oe;
  logic [31:0] buttons = 32'h0;
  logic        pak_present = 1'b0;
  logic        busy, cmd_valid, rx_error;
  logic [7:0]  cmd_byte;

  assign joy_in = ~(console_low | joy_oe);
  always #5 clk = ~clk;

  n64_joybus_device #(.US_CYCLES(US), .TIMEOUT_US(4), .GAP_US(2)) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .joy_in      (joy_in),
    .joy_oe      (joy_oe),
    .buttons     (buttons),
    .pak_present (pak_present),
    .busy        (busy),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .rx_error    (rx_error)
  );

  int assertions = 0;
  int failures   = 0;

  logic [7:0] exp_q[$];
  int cmd_valid_cnt = 0;
  int rx_error_cnt  = 0;
  int oe_rises      = 0;

  // Response decoder: measures joy_oe pulses at the falling clock edge.
  initial begin
    int hi_len, lo_len, mon_bits, prev_hi;
    logic prev_oe;
    logic [7:0] mon_byte, exp;
    hi_len = 0; lo_len = 0; mon_bits = 0; prev_hi = 0; prev_oe = 1'b0;
    mon_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_l) begin
        hi_len = 0; lo_len = 0; mon_bits = 0; prev_hi = 0; prev_oe = 1'b0;
      end else begin
        if (cmd_valid) cmd_valid_cnt++;
        if (rx_error)  rx_error_cnt++;
        if (joy_oe && !prev_oe) begin
          oe_rises++;
          if (prev_hi == US || prev_hi == 3*US) begin
            assertions++;
            if (lo_len != 4*US - prev_hi) begin
              failures++;
              $display("FAIL bit_release: released %0d cycles, required %0d", lo_len, 4*US - prev_hi);
            end
          end
          hi_len = 0;
        end
        if (joy_oe) begin
          hi_len++;
        end else begin
          if (prev_oe) begin
            if (hi_len == US || hi_len == 3*US) begin
              mon_byte = {mon_byte[6:0], (hi_len == US)};
              mon_bits++;
              if (mon_bits % 8 == 0) begin
                assertions++;
                if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL resp_byte: got unexpected byte %02h, required none", mon_byte);
                end else begin
                  exp = exp_q.pop_front();
                  if (mon_byte !== exp) begin
                    failures++;
                    $display("FAIL resp_byte: got %02h, required %02h", mon_byte, exp);
                  end
                end
              end
            end else if (hi_len == 2*US) begin
              assertions++;
              if (mon_bits == 0 || mon_bits % 8 != 0) begin
                failures++;
                $display("FAIL stop_pos: stop after %0d bits, required a whole number of bytes", mon_bits);
              end
              mon_bits = 0;
            end else begin
              assertions++;
              failures++;
              $display("FAIL pulse_len: low pulse %0d cycles, required %0d, %0d or %0d", hi_len, US, 3*US, 2*US);
            end
            prev_hi = hi_len;
            lo_len  = 0;
          end
          lo_len++;
        end
        prev_oe = joy_oe;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    console_low = 1'b1;
    repeat (b ? US : 3*US) tick();
    console_low = 1'b0;
    for (int i = 0; i < (b ? 3*US : US); i++) begin
      if (glitch && b && i == 6) begin
        console_low = 1'b1;
        tick();
        console_low = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) send_bit(c[7-i], glitch);
    console_low = 1'b1;
    repeat (US) tick();
    console_low = 1'b0;
  endtask

  task automatic await_cmd(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (cmd_valid) seen = 1'b1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy && !joy_oe) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    assertions++; if (joy_oe !== 1'b0)    begin failures++; $display("FAIL rst_joy_oe: got %b, required 0", joy_oe); end
    assertions++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
    assertions++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid: got %b, required 0", cmd_valid); end
    assertions++; if (cmd_byte !== 8'h00) begin failures++; $display("FAIL rst_cmd_byte: got %02h, required 00", cmd_byte); end
    assertions++; if (rx_error !== 1'b0)  begin failures++; $display("FAIL rst_rx_error: got %b, required 0", rx_error); end
    reset_l = 1'b1;
    repeat (10) tick();
    assertions++; if (busy !== 1'b0 || joy_oe !== 1'b0) begin failures++; $display("FAIL post_rst_idle: got busy=%b joy_oe=%b, required 0 0", busy, joy_oe); end
  endtask

  task automatic test_state();
    bit seen, ok;
    int base, lat;
    base = cmd_valid_cnt;
    buttons = 32'h8000_1234;
    exp_q.push_back(8'h80); exp_q.push_back(8'h00);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    send_frame(CMD_STATE, 8, 1'b0);
    await_cmd(seen);
    assertions++; if (!seen) begin failures++; $display("FAIL state_accept: got no cmd_valid, required a pulse"); end
    buttons = 32'hFFFF_FFFF;  // must not affect the frame in flight
    assertions++; if (cmd_byte !== CMD_STATE) begin failures++; $display("FAIL state_cmd_byte: got %02h, required 01", cmd_byte); end
    lat = 0;
    while (!joy_oe && lat < 20) begin tick(); lat++; end
    assertions++; if (lat != US) begin failures++; $display("FAIL turnaround: got %0d cycles, required %0d", lat, US); end
    wait_done(ok);
    assertions++; if (!ok) begin failures++; $display("FAIL state_done: got %0d bytes pending busy=%b, required 0 and idle", exp_q.size(), busy); end
    assertions++; if (cmd_valid_cnt != base + 1) begin failures++; $display("FAIL state_valid_cnt: got %0d pulses, required 1", cmd_valid_cnt - base); end
  endtask

  task automatic test_info();
    bit seen, ok;
    pak_present = 1'b0;
    exp_q.push_back(8'h05); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    send_frame(CMD_INFO, 8, 1'b0);
    await_cmd(seen);
    assertions++; if (!seen || cmd_byte !== CMD_INFO) begin failures++; $display("FAIL info_accept: got seen=%b cmd_byte=%02h, required 1 00", seen, cmd_byte); end
    wait_done(ok);
    assertions++; if (!ok) begin failures++; $display("FAIL info_done: got %0d bytes pending, required 0", exp_q.size()); end
    pak_present = 1'b1;
    exp_q.push_back(8'h05); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    send_frame(CMD_RESET, 8, 1'b0);
    await_cmd(seen);
    assertions++; if (!seen || cmd_byte !== CMD_RESET) begin failures++; $display("FAIL reset_cmd_accept: got seen=%b cmd_byte=%02h, required 1 ff", seen, cmd_byte); end
    wait_done(ok);
    assertions++; if (!ok) begin failures++; $display("FAIL reset_cmd_done: got %0d bytes pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reject();
    int base_err, base_rise, base_cmd;
    base_err = rx_error_cnt; base_rise = oe_rises; base_cmd = cmd_valid_cnt;
    send_frame(8'h02, 8, 1'b0);
    repeat (40) tick();
    assertions++; if (rx_error_cnt != base_err + 1) begin failures++; $display("FAIL bad_cmd_err: got %0d pulses, required 1", rx_error_cnt - base_err); end
    send_frame(CMD_STATE, 7, 1'b0);
    repeat (40) tick();
    assertions++; if (rx_error_cnt != base_err + 2) begin failures++; $display("FAIL short_frame_err: got %0d pulses, required 2", rx_error_cnt - base_err); end
    assertions++; if (oe_rises != base_rise) begin failures++; $display("FAIL reject_drive: got %0d joy_oe pulses, required 0", oe_rises - base_rise); end
    assertions++; if (cmd_valid_cnt != base_cmd) begin failures++; $display("FAIL reject_valid: got %0d cmd_valid pulses, required 0", cmd_valid_cnt - base_cmd); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL reject_busy: got %b, required 0", busy); end
  endtask

  task automatic test_long_low();
    int base_err, first;
    bit seen, ok;
    base_err = rx_error_cnt;
    first = -1;
    console_low = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      tick();
      if (rx_error && first < 0) first = i;
      if (i == 24) console_low = 1'b0;
      if (i == 36) begin
        assertions++; if (busy !== 1'b1) begin failures++; $display("FAIL rx_err_hold: got busy=%b, required 1", busy); end
      end
    end
    assertions++; if (first != 24 + FILT_LAT) begin failures++; $display("FAIL rx_err_time: got cycle %0d, required %0d", first, 24 + FILT_LAT); end
    assertions++; if (rx_error_cnt != base_err + 1) begin failures++; $display("FAIL rx_err_cnt: got %0d pulses, required 1", rx_error_cnt - base_err); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL rx_err_exit: got busy=%b, required 0", busy); end
    buttons = 32'h0F0F_A5C3;
    exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
    exp_q.push_back(8'hA5); exp_q.push_back(8'hC3);
    send_frame(CMD_STATE, 8, 1'b0);
    await_cmd(seen);
    assertions++; if (!seen || cmd_byte !== CMD_STATE) begin failures++; $display("FAIL after_err_accept: got seen=%b cmd_byte=%02h, required 1 01", seen, cmd_byte); end
    wait_done(ok);
    assertions++; if (!ok) begin failures++; $display("FAIL after_err_done: got %0d bytes pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_tx();
    bit seen, ok, hit;
    buttons = 32'h1357_9BDF;
    exp_q.push_back(8'h13); exp_q.push_back(8'h57);
    exp_q.push_back(8'h9B); exp_q.push_back(8'hDF);
    send_frame(CMD_STATE, 8, 1'b0);
    await_cmd(seen);
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      tick();
      if (exp_q.size() <= 3 && joy_oe) hit = 1'b1;
    end
    assertions++; if (!hit) begin failures++; $display("FAIL mid_tx_reach: got no drive in byte 2, required drive"); end
    reset_l = 1'b0;
    #1;
    assertions++; if (joy_oe !== 1'b0) begin failures++; $display("FAIL async_release: got joy_oe=%b, required 0", joy_oe); end
    assertions++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || rx_error !== 1'b0 || cmd_byte !== 8'h00) begin
      failures++;
      $display("FAIL mid_tx_reset_vals: got busy=%b valid=%b err=%b cmd=%02h, required 0 0 0 00", busy, cmd_valid, rx_error, cmd_byte);
    end
    exp_q.delete();
    repeat (3) tick();
    reset_l = 1'b1;
    repeat (10) tick();
    pak_present = 1'b1;
    exp_q.push_back(8'h05); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    send_frame(CMD_INFO, 8, 1'b0);
    await_cmd(seen);
    assertions++; if (!seen || cmd_byte !== CMD_INFO) begin failures++; $display("FAIL post_rst_accept: got seen=%b cmd_byte=%02h, required 1 00", seen, cmd_byte); end
    wait_done(ok);
    assertions++; if (!ok) begin failures++; $display("FAIL post_rst_done: got %0d bytes pending, required 0", exp_q.size()); end
  endtask

`ifdef JOYBUS_GLITCH_FILTER_EN
  task automatic test_glitch();
    int base_err;
    bit seen, ok;
    base_err = rx_error_cnt;
    for (int g = 0; g < 4; g++) begin
      console_low = 1'b1;
      tick();
      console_low = 1'b0;
      repeat (10) tick();
    end
    repeat (30) tick();
    assertions++; if (rx_error_cnt != base_err || busy !== 1'b0) begin failures++; $display("FAIL idle_glitch: got err=%0d busy=%b, required 0 0", rx_error_cnt - base_err, busy); end
    buttons = 32'hBEEF_0001;
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    send_frame(CMD_STATE, 8, 1'b1);
    await_cmd(seen);
    assertions++; if (!seen || cmd_byte !== CMD_STATE) begin failures++; $display("FAIL glitch_accept: got seen=%b cmd_byte=%02h, required 1 01", seen, cmd_byte); end
    wait_done(ok);
    assertions++; if (!ok) begin failures++; $display("FAIL glitch_done: got %0d bytes pending, required 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_state();
    test_info();
    test_reject();
    test_long_low();
    test_reset_mid_tx();
`ifdef JOYBUS_GLITCH_FILTER_EN
    test_glitch();
`endif
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
